// File: rtl/rtc_write_buffer.sv
// rtc_write_buffer: buffered, address-checked write channel from the microcontroller
// interface to the register file. Valid writes are queued in a DEPTH-entry FIFO and
// presented as a one-hot select plus data/strobes. Writes to unmapped addresses are
// dropped, pulsed on o_wr_err and counted in a saturating counter.
// Optional feature macro: RTC_WR_STRB_EN (store and forward byte strobes; when
// undefined, strobes are forced to all ones for every presented entry).
module rtc_write_buffer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DEPTH  = 4,
  parameter logic [(2**ADDR_W)-1:0] VALID_MASK = 64'h0000_0001_FF03_FF2F
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_wr_en,
  input  logic [ADDR_W-1:0]       i_addr,
  input  logic [DATA_W-1:0]       i_bus_data,
  input  logic [DATA_W/8-1:0]     i_strb,
  output logic                    o_wr_ready,
  output logic                    o_wr_err,
  output logic [7:0]              o_err_cnt,
  input  logic                    i_err_clr,
  output logic                    o_wr_valid,
  input  logic                    i_reg_ready,
  output logic [(2**ADDR_W)-1:0]  o_wr_sel,
  output logic [DATA_W-1:0]       o_reg_w_bus,
  output logic [DATA_W/8-1:0]     o_reg_w_strb
);

  localparam int unsigned SEL_W  = 2**ADDR_W;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned PTR_W  = IDX_W + 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic              empty;
  logic              full;
  logic              accept;
  logic              push;
  logic              pop;
  logic              drop;

  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  // Status derived purely from registered pointers (no path from i_reg_ready).
  always_comb begin
    empty = (wr_ptr == rd_ptr);
    full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
            (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
  end

  assign o_wr_ready = !full && !i_reset;
  assign o_wr_valid = !empty;

  // Handshake decode: an accepted write is either queued or dropped.
  always_comb begin
    accept = i_wr_en && o_wr_ready;
    push   = accept && VALID_MASK[i_addr];
    drop   = accept && !VALID_MASK[i_addr];
    pop    = o_wr_valid && i_reg_ready;
  end

  // FIFO pointers; simultaneous push and pop advance both.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FIFO storage; contents need no reset since outputs are gated by o_wr_valid.
  always_ff @(posedge i_clk) begin
    if (push) begin
      addr_mem[wr_ptr[IDX_W-1:0]] <= i_addr;
      data_mem[wr_ptr[IDX_W-1:0]] <= i_bus_data;
    end
  end

  // Error pulse and saturating drop counter; clear wins over an increment.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_wr_err  <= 1'b0;
      o_err_cnt <= 8'h00;
    end else begin
      o_wr_err <= drop;
      if (i_err_clr) begin
        o_err_cnt <= 8'h00;
      end else if (drop && (o_err_cnt != 8'hFF)) begin
        o_err_cnt <= o_err_cnt + 8'd1;
      end
    end
  end

  assign head_addr = addr_mem[rd_ptr[IDX_W-1:0]];
  assign head_data = data_mem[rd_ptr[IDX_W-1:0]];

  // Head decode: one-hot select and data, zeroed when nothing is presented.
  always_comb begin
    o_wr_sel    = '0;
    o_reg_w_bus = '0;
    if (o_wr_valid) begin
      o_wr_sel    = {{(SEL_W-1){1'b0}}, 1'b1} << head_addr;
      o_reg_w_bus = head_data;
    end
  end

`ifdef RTC_WR_STRB_EN
  logic [STRB_W-1:0] strb_mem [DEPTH];

  // Strobe storage alongside address and data.
  always_ff @(posedge i_clk) begin
    if (push) strb_mem[wr_ptr[IDX_W-1:0]] <= i_strb;
  end

  // Forward stored strobes for the head entry.
  always_comb begin
    o_reg_w_strb = '0;
    if (o_wr_valid) o_reg_w_strb = strb_mem[rd_ptr[IDX_W-1:0]];
  end
`else
  // Strobes are not stored in this build.
  logic unused_strb;
  assign unused_strb = ^i_strb;

  // Every presented entry writes all byte lanes.
  always_comb begin
    o_reg_w_strb = {STRB_W{o_wr_valid}};
  end
`endif

endmodule

// File: tb/tb_rtc_write_buffer.sv
// tb_rtc_write_buffer: directed self-checking bench for rtc_write_buffer.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_rtc_write_buffer;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [5:0]  addr;
  logic [31:0] bus_data;
  logic [3:0]  strb;
  logic        wr_ready;
  logic        wr_err;
  logic [7:0]  err_cnt;
  logic        err_clr;
  logic        wr_valid;
  logic        reg_ready;
  logic [63:0] wr_sel;
  logic [31:0] reg_w_bus;
  logic [3:0]  reg_w_strb;

  int checks = 0;
  int errors = 0;

  rtc_write_buffer dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_wr_en      (wr_en),
    .i_addr       (addr),
    .i_bus_data   (bus_data),
    .i_strb       (strb),
    .o_wr_ready   (wr_ready),
    .o_wr_err     (wr_err),
    .o_err_cnt    (err_cnt),
    .i_err_clr    (err_clr),
    .o_wr_valid   (wr_valid),
    .i_reg_ready  (reg_ready),
    .o_wr_sel     (wr_sel),
    .o_reg_w_bus  (reg_w_bus),
    .o_reg_w_strb (reg_w_strb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] onehot(input logic [5:0] a);
    logic [63:0] v;
    v = 64'd1 << a;
    return v;
  endfunction

`ifdef RTC_WR_STRB_EN
  localparam logic [3:0] StrbExp = 4'b0101;
`else
  localparam logic [3:0] StrbExp = 4'b1111;
`endif

  logic [5:0]  valid_addrs [24];
  logic [5:0]  stream_addr [20];
  logic [31:0] stream_data [20];
  logic [5:0]  q_addr [5];

  initial begin
    for (int i = 0; i < 4; i++)  valid_addrs[i] = 6'(i);
    valid_addrs[4] = 6'd5;
    for (int i = 0; i < 10; i++) valid_addrs[5 + i] = 6'(8 + i);
    for (int i = 0; i < 9; i++)  valid_addrs[15 + i] = 6'(24 + i);
    q_addr[0] = 6'd0; q_addr[1] = 6'd1; q_addr[2] = 6'd2; q_addr[3] = 6'd3; q_addr[4] = 6'd8;

    rst = 1'b1; wr_en = 1'b0; addr = '0; bus_data = '0; strb = 4'hF;
    err_clr = 1'b0; reg_ready = 1'b0;

    // Reset state
    @(negedge clk); @(negedge clk);
    check_val("rst_ready", 64'(wr_ready), 64'd0);
    check_val("rst_valid", 64'(wr_valid), 64'd0);
    check_val("rst_cnt", 64'(err_cnt), 64'd0);
    check_val("rst_sel", wr_sel, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check_val("rel_ready", 64'(wr_ready), 64'd1);

    // Single valid write, popped immediately
    reg_ready = 1'b1; wr_en = 1'b1; addr = 6'h05; bus_data = 32'hDEAD_BEEF;
    @(negedge clk);
    wr_en = 1'b0;
    check_val("t1_valid", 64'(wr_valid), 64'd1);
    check_val("t1_sel", wr_sel, onehot(6'd5));
    check_val("t1_bus", 64'(reg_w_bus), 64'hDEAD_BEEF);
    check_val("t1_strb", 64'(reg_w_strb), 64'hF);
    check_val("t1_err", 64'(wr_err), 64'd0);
    @(negedge clk);
    check_val("t1_popped", 64'(wr_valid), 64'd0);
    check_val("t1_idle_bus", 64'(reg_w_bus), 64'd0);
    check_val("t1_idle_strb", 64'(reg_w_strb), 64'd0);

    // Invalid write, error pulse and counter
    wr_en = 1'b1; addr = 6'h04; bus_data = 32'h1234_5678;
    @(negedge clk);
    wr_en = 1'b0;
    check_val("t2_err", 64'(wr_err), 64'd1);
    check_val("t2_cnt", 64'(err_cnt), 64'd1);
    check_val("t2_valid", 64'(wr_valid), 64'd0);
    @(negedge clk);
    check_val("t2_err_pulse", 64'(wr_err), 64'd0);
    wr_en = 1'b1;
    for (int i = 0; i < 256; i++) @(negedge clk);
    wr_en = 1'b0;
    check_val("t2_sat", 64'(err_cnt), 64'hFF);
    wr_en = 1'b1; err_clr = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; err_clr = 1'b0;
    check_val("t2_clr", 64'(err_cnt), 64'd0);
    check_val("t2_clr_err", 64'(wr_err), 64'd1);

    // Fill while stalled, then drain in order
    reg_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; addr = q_addr[i]; bus_data = 32'h100 + 32'(i);
      @(negedge clk);
    end
    check_val("t3_full_ready", 64'(wr_ready), 64'd0);
    addr = q_addr[4]; bus_data = 32'h104;
    for (int i = 0; i < 2; i++) begin
      check_val("t3_stall_sel", wr_sel, onehot(6'd0));
      check_val("t3_stall_bus", 64'(reg_w_bus), 64'h100);
      @(negedge clk);
    end
    reg_ready = 1'b1;
    check_val("t3_head0", wr_sel, onehot(6'd0));
    @(negedge clk);
    check_val("t3_ready_back", 64'(wr_ready), 64'd1);
    check_val("t3_head1", wr_sel, onehot(6'd1));
    check_val("t3_bus1", 64'(reg_w_bus), 64'h101);
    @(negedge clk);
    wr_en = 1'b0;
    for (int i = 2; i < 5; i++) begin
      check_val("t3_order_sel", wr_sel, onehot(q_addr[i]));
      check_val("t3_order_bus", 64'(reg_w_bus), 64'h100 + 64'(i));
      @(negedge clk);
    end
    check_val("t3_drained", 64'(wr_valid), 64'd0);

    // Streaming push/pop through pointer wrap
    for (int i = 0; i < 20; i++) begin
      stream_addr[i] = valid_addrs[$urandom_range(23, 0)];
      stream_data[i] = $urandom;
    end
    for (int k = 0; k <= 20; k++) begin
      if (k < 20) begin
        wr_en = 1'b1; addr = stream_addr[k]; bus_data = stream_data[k];
      end else begin
        wr_en = 1'b0;
      end
      if (k >= 1) begin
        check_val("t4_valid", 64'(wr_valid), 64'd1);
        check_val("t4_sel", wr_sel, onehot(stream_addr[k-1]));
        check_val("t4_bus", 64'(reg_w_bus), 64'(stream_data[k-1]));
      end
      @(negedge clk);
    end
    check_val("t4_end", 64'(wr_valid), 64'd0);

    // Asynchronous reset with queued entries and nonzero counter
    wr_en = 1'b1; addr = 6'h06;
    for (int i = 0; i < 7; i++) @(negedge clk);
    reg_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      addr = 6'(9 + i); bus_data = 32'hA0 + 32'(i);
      @(negedge clk);
    end
    wr_en = 1'b0;
    check_val("t5_cnt7", 64'(err_cnt), 64'd7);
    check_val("t5_queued", 64'(wr_valid), 64'd1);
    rst = 1'b1;
    #1;
    check_val("t5_rst_valid", 64'(wr_valid), 64'd0);
    check_val("t5_rst_sel", wr_sel, 64'd0);
    check_val("t5_rst_bus", 64'(reg_w_bus), 64'd0);
    check_val("t5_rst_ready", 64'(wr_ready), 64'd0);
    check_val("t5_rst_cnt", 64'(err_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("t5_rel_ready", 64'(wr_ready), 64'd1);
    check_val("t5_rel_empty", 64'(wr_valid), 64'd0);
    check_val("t5_rel_cnt", 64'(err_cnt), 64'd0);

    // Strobe forwarding
    reg_ready = 1'b1; wr_en = 1'b1; addr = 6'd12; bus_data = 32'hCAFE_F00D; strb = 4'b0101;
    @(negedge clk);
    wr_en = 1'b0;
    check_val("t6_strb", 64'(reg_w_strb), 64'(StrbExp));
    check_val("t6_sel", wr_sel, onehot(6'd12));
    @(negedge clk);
    check_val("t6_idle_strb", 64'(reg_w_strb), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rtc_write_buffer.md
# rtc_write_buffer

Parametrised, buffered write channel for the Microcontroller Interface. It accepts microcontroller writes through a valid/ready handshake and checks each address against a configurable register map. Valid writes are queued in a small FIFO and issued to the register file as a one-hot select plus data and byte strobes under a second valid/ready handshake. Invalid writes are dropped, flagged, and counted.

## Interface
- DATA_W, 32, write data width; multiple of 8
- ADDR_W, 6, address width; select vector width SEL_W = 2**ADDR_W
- DEPTH, 4, FIFO entries; power of 2, ≥2
- VALID_MASK, 64'h0000_0001_FF03_FF2F, bit n set = address n writable (0–3, 5, 8–17, 24–32)
- i_clk  in  1  clock, all state on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_wr_en  in  1  upstream write request (valid)
- i_addr  in  ADDR_W  write address
- i_bus_data  in  DATA_W  write data
- i_strb  in  DATA_W/8  byte-lane strobes
- o_wr_ready  out  1  upstream may push
- o_wr_err  out  1  one-cycle pulse: invalid address dropped
- o_err_cnt  out  8  saturating count of dropped writes
- i_err_clr  in  1  synchronous clear of o_err_cnt
- o_wr_valid  out  1  head entry presented to register file
- i_reg_ready  in  1  register file consumes head
- o_wr_sel  out  SEL_W  one-hot select, bit index = address; all-zero when o_wr_valid=0
- o_reg_w_bus  out  DATA_W  head data; 0 when o_wr_valid=0
- o_reg_w_strb  out  DATA_W/8  head strobes; 0 when o_wr_valid=0

## Operation
- Accept: i_wr_en & o_wr_ready at rising edge.
- Accepted write with VALID_MASK[i_addr]=1 is enqueued as {addr, data, strb}.
- Accepted write with VALID_MASK[i_addr]=0 is not enqueued. o_wr_err is 1 the next cycle only. o_err_cnt increments, saturating at 8'hFF.
- i_err_clr wins over a same-cycle increment: the counter goes to 0.
- o_wr_ready = !full & !i_reset.
- Drain: o_wr_valid = !empty. Entry pops when o_wr_valid & i_reg_ready.
- Outputs are decoded combinationally from the head entry.
- Write and read pointers are log2(DEPTH)+1 bits, wrapping naturally. Full/empty are derived from the MSB compare.
- Simultaneous push and pop:
  - Count is unchanged; both pointers advance.
  - When empty, only the push occurs (nothing to pop).
  - When full, push is blocked by ready.
- Valid/ready rules:
  - o_wr_valid must not deassert, and head contents must not change, until popped.
  - Upstream holds i_addr, i_bus_data and i_strb only for the accept cycle.
- Reset (asynchronous, any time including mid-drain):
  - Pointers, count, o_wr_err and o_err_cnt all go to 0.
  - FIFO contents are discarded.
  - o_wr_valid, o_wr_sel, o_reg_w_bus and o_reg_w_strb become 0.
  - o_wr_ready is 0 while i_reset is high and 1 the first cycle after release.

## Timing
- Accept-to-o_wr_valid latency: 1 cycle when the FIFO is empty.
- Accept-to-o_wr_err latency: 1 cycle.
- Full throughput: one push and one pop per cycle sustained.
- o_wr_ready reflects the registered count only, with no combinational path from i_reg_ready.
- o_wr_valid and the head outputs depend only on registered state.

## Configuration
- RTC_WR_STRB_EN
  - Defined: i_strb is stored and forwarded on o_reg_w_strb. An accepted valid write with i_strb = 0 is enqueued unchanged.
  - Undefined: i_strb is ignored and not stored. o_reg_w_strb = all ones whenever o_wr_valid=1, otherwise 0.
- Port list is identical in both builds.

## Test plan
- Reset, then single write addr 6'h05, data 32'hDEAD_BEEF, i_reg_ready=1 → next cycle o_wr_valid=1, o_wr_sel=bit 5, o_reg_w_bus=32'hDEAD_BEEF; pops that cycle; o_wr_err stays 0.
- Write addr 6'h04 (invalid) → no o_wr_valid; o_wr_err pulses 1 cycle; o_err_cnt=1. 256 further invalid writes → o_err_cnt=8'hFF. i_err_clr together with an invalid write → o_err_cnt=0.
- i_reg_ready=0, push 5 valid writes (addrs 0,1,2,3,8) → 4 accepted, o_wr_ready=0 after the 4th. Raise i_reg_ready → pops in order 0,1,2,3, then the 5th accepted once ready returns. Data is unchanged while stalled.
- Continuous push and pop for 20 cycles through pointer wrap, random valid addresses → output sequence equals input sequence; no bubbles after the first cycle.
- Assert i_reset with 3 entries queued and o_err_cnt=7 → same cycle o_wr_valid=0, o_wr_sel=0, o_reg_w_bus=0, o_wr_ready=0; after release o_err_cnt=0, FIFO empty, o_wr_ready=1.
- With RTC_WR_STRB_EN defined, write i_strb=4'b0101 → o_reg_w_strb=4'b0101. With it undefined → o_reg_w_strb=4'b1111.
